drain_write_scheduler: RTL and testbench

Sequences the drain of the accumulator array into the per-column drain FIFOs. After a compute starts, it waits out the compute latency and then drives the systolic, column-skewed FIFO write enables together with the array shift strobe. It stalls the whole array when any targeted FIFO is full and reports completion. It sits between the compute-start control and the drain FIFO bank that feeds the byte-serial drain reader.

---
 rtl/drain_write_scheduler_pkg.sv | 21 ++
 rtl/drain_write_scheduler_window.sv | 19 +
 rtl/drain_write_scheduler.sv | 122 ++++++++++++
 tb/tb_drain_write_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/drain_write_scheduler_pkg.sv
// rtl/drain_write_scheduler_pkg.sv - shared types and sizing constants for the drain write scheduler
package drain_write_scheduler_pkg;

   // Array dimensions used when the scheduler is instantiated in the vTPU datapath
   localparam int X_SCALED = 4;
   localparam int Y_SCALED = 4;

   // Scheduler sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } drain_sched_state_t;

   // Width of a counter that must hold values 0..max_val, never less than one bit
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/drain_write_scheduler_window.sv
// rtl/drain_write_scheduler_window.sv - systolic column window mask for a given drain step
module drain_window_mask #(
   parameter int X_ROWS = 4,
   parameter int Y_COLS = 4,
   parameter int T_W    = 3
) (
   input  logic [T_W-1:0]    i_t,
   output logic [Y_COLS-1:0] o_mask
);

   // Column c is live for X_ROWS steps starting at step c (diagonal skew of the array)
   always_comb begin
      o_mask = '0;
      for (int c = 0; c < Y_COLS; c++) begin
         o_mask[c] = (int'(i_t) >= c) && (int'(i_t) < c + X_ROWS);
      end
   end

endmodule

// File: rtl/drain_write_scheduler.sv
// rtl/drain_write_scheduler.sv - waits out compute latency then drives skewed drain FIFO writes with global stall
module drain_write_scheduler
   import drain_write_scheduler_pkg::*;
#(
   parameter int X_ROWS      = X_SCALED,
   parameter int Y_COLS      = Y_SCALED,
   parameter int COMPUTE_LAT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_compute,
   input  logic              abort,
   input  logic [Y_COLS-1:0] fifo_full,
   output logic [Y_COLS-1:0] wr_en,
   output logic              acc_shift,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int T_W  = cnt_width(X_ROWS + Y_COLS - 1);
   localparam int WC_W = cnt_width(COMPUTE_LAT);

   localparam logic [T_W-1:0]  T_LAST  = T_W'(X_ROWS + Y_COLS - 2);
   localparam logic [WC_W-1:0] WC_LOAD = (COMPUTE_LAT > 0) ? WC_W'(COMPUTE_LAT - 1) : '0;

   drain_sched_state_t  r_state;
   logic [T_W-1:0]      r_t;
   logic [WC_W-1:0]     r_wait_cnt;
   logic                r_busy;
   logic                r_done;
   logic                r_overrun;

   logic                w_in_drain;
   logic [Y_COLS-1:0]   w_raw_window;
   logic [Y_COLS-1:0]   w_window;
   logic                w_stall;

   drain_window_mask #(
      .X_ROWS (X_ROWS),
      .Y_COLS (Y_COLS),
      .T_W    (T_W)
   ) u_window (
      .i_t    (r_t),
      .o_mask (w_raw_window)
   );

   // Window is only meaningful while draining; a full FIFO outside its window must not stall
   always_comb begin
      w_in_drain = (r_state == DRAIN);
      w_window   = w_in_drain ? w_raw_window : '0;
      w_stall    = |(w_window & fifo_full);
   end

   assign wr_en     = w_window & {Y_COLS{~w_stall}};
   assign acc_shift = w_in_drain & ~w_stall;
   assign stall     = w_stall;
   assign busy      = r_busy;
   assign done      = r_done;
   assign overrun   = r_overrun;

   // Pass sequencer: latency wait, lockstep drain stepping, completion pulse and abort
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_t        <= '0;
         r_wait_cnt <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start_compute && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end
         if (r_state == IDLE) begin
            if (start_compute) begin
               r_overrun  <= 1'b0;
               r_busy     <= 1'b1;
               r_t        <= '0;
               r_wait_cnt <= WC_LOAD;
               r_state    <= (COMPUTE_LAT == 0) ? DRAIN : WAIT;
            end
         end else if (abort) begin
            r_state    <= IDLE;
            r_t        <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
         end else begin
            case (r_state)
               WAIT: begin
                  if (r_wait_cnt == '0) begin
                     r_state <= DRAIN;
                  end else begin
                     r_wait_cnt <= r_wait_cnt - 1'b1;
                  end
               end
               DRAIN: begin
                  if (!w_stall) begin
                     if (r_t == T_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_t <= r_t + 1'b1;
                     end
                  end
               end
               DONE: begin
                  r_state <= IDLE;
                  r_t     <= '0;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_drain_write_scheduler.sv
// tb/tb_drain_write_scheduler.sv - directed self-checking bench for drain_write_scheduler
module tb_drain_write_scheduler;

   logic       clk;
   logic       rst;
   logic       start_compute;
   logic       abort;
   logic [3:0] fifo_full;

   logic [3:0] wr_en,  wr_en1;
   logic       acc_shift, acc_shift1;
   logic       stall, stall1;
   logic       busy, busy1;
   logic       done, done1;
   logic       overrun, overrun1;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] wr_log  [64];
   logic       sh_log  [64];
   logic       st_log  [64];
   logic       bz_log  [64];
   logic       dn_log  [64];
   logic       ov_log  [64];
   logic [3:0] wr1_log [64];
   logic       dn1_log [64];

   drain_write_scheduler #(.X_ROWS(4), .Y_COLS(4), .COMPUTE_LAT(8)) dut (
      .clk(clk), .rst(rst), .start_compute(start_compute), .abort(abort),
      .fifo_full(fifo_full), .wr_en(wr_en), .acc_shift(acc_shift), .stall(stall),
      .busy(busy), .done(done), .overrun(overrun)
   );

   drain_write_scheduler #(.X_ROWS(4), .Y_COLS(4), .COMPUTE_LAT(0)) dut0 (
      .clk(clk), .rst(rst), .start_compute(start_compute), .abort(abort),
      .fifo_full(fifo_full), .wr_en(wr_en1), .acc_shift(acc_shift1), .stall(stall1),
      .busy(busy1), .done(done1), .overrun(overrun1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic int first_wr(input int col, input int from);
      for (int c = from; c < 64; c++) if (wr_log[c][col]) return c;
      return -1;
   endfunction

   function automatic int last_wr(input int col);
      for (int c = 63; c >= 0; c--) if (wr_log[c][col]) return c;
      return -1;
   endfunction

   function automatic int cnt_wr(input int col);
      int n = 0;
      for (int c = 0; c < 64; c++) if (wr_log[c][col]) n++;
      return n;
   endfunction

   function automatic int first_done();
      for (int c = 0; c < 64; c++) if (dn_log[c]) return c;
      return -1;
   endfunction

   function automatic int cnt_done();
      int n = 0;
      for (int c = 0; c < 64; c++) if (dn_log[c]) n++;
      return n;
   endfunction

   function automatic int cnt_stall();
      int n = 0;
      for (int c = 0; c < 64; c++) if (st_log[c]) n++;
      return n;
   endfunction

   function automatic int first_wr1(input int col);
      for (int c = 0; c < 64; c++) if (wr1_log[c][col]) return c;
      return -1;
   endfunction

   function automatic int first_done1();
      for (int c = 0; c < 64; c++) if (dn1_log[c]) return c;
      return -1;
   endfunction

   // One pass of n cycles; cycle 0 begins just after the next rising edge.
   // Inputs change 1ns after the edge, outputs are logged on the falling edge.
   task automatic run(input int n, input int st0, input int st1, input int ab,
                      input int fcol, input int ff, input int fl, input int rc);
      for (int c = 0; c < 64; c++) begin
         wr_log[c] = '0; sh_log[c] = 0; st_log[c] = 0; bz_log[c] = 0;
         dn_log[c] = 0; ov_log[c] = 0; wr1_log[c] = '0; dn1_log[c] = 0;
      end
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         start_compute = (c == st0) || (c == st1);
         abort         = (c == ab);
         rst           = (c == rc);
         fifo_full     = (fcol >= 0 && c >= ff && c <= fl) ? (4'b0001 << fcol) : 4'b0000;
         @(negedge clk);
         wr_log[c]  = wr_en;
         sh_log[c]  = acc_shift;
         st_log[c]  = stall;
         bz_log[c]  = busy;
         dn_log[c]  = done;
         ov_log[c]  = overrun;
         wr1_log[c] = wr_en1;
         dn1_log[c] = done1;
      end
      @(posedge clk);
      #1;
      start_compute = 0; abort = 0; rst = 0; fifo_full = '0;
   endtask

   initial begin
      rst = 1'b1; start_compute = 0; abort = 0; fifo_full = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en",   int'(wr_en),   0);
      chk("rst_shift",   int'(acc_shift), 0);
      chk("rst_stall",   int'(stall),   0);
      chk("rst_busy",    int'(busy),    0);
      chk("rst_done",    int'(done),    0);
      chk("rst_overrun", int'(overrun), 0);
      rst = 1'b0;

      // Nominal pass
      run(20, 0, -1, -1, -1, 0, 0, -1);
      chk("nom_busy0",    int'(bz_log[0]), 0);
      chk("nom_busy1",    int'(bz_log[1]), 1);
      chk("nom_wr9",      int'(wr_log[9]), 4'b0001);
      chk("nom_wr12",     int'(wr_log[12]), 4'b1111);
      chk("nom_c0_first", first_wr(0, 0), 9);
      chk("nom_c0_last",  last_wr(0), 12);
      chk("nom_c3_first", first_wr(3, 0), 12);
      chk("nom_c3_last",  last_wr(3), 15);
      chk("nom_writes",   cnt_wr(0) + cnt_wr(1) + cnt_wr(2) + cnt_wr(3), 16);
      chk("nom_done",     first_done(), 16);
      chk("nom_done_cnt", cnt_done(), 1);
      chk("nom_busy16",   int'(bz_log[16]), 1);
      chk("nom_busy17",   int'(bz_log[17]), 0);
      chk("lat0_first",   first_wr1(0), 1);
      chk("lat0_c3",      first_wr1(3), 4);
      chk("lat0_done",    first_done1(), 8);

      // Stall on column 2, cycles 11..13
      run(24, 0, -1, -1, 2, 11, 13, -1);
      for (int c = 11; c <= 13; c++) begin
         chk($sformatf("stall_wr%0d", c),  int'(wr_log[c]), 0);
         chk($sformatf("stall_sh%0d", c),  int'(sh_log[c]), 0);
         chk($sformatf("stall_st%0d", c),  int'(st_log[c]), 1);
      end
      chk("stall_wr14",   int'(wr_log[14]), 4'b0111);
      chk("stall_sh14",   int'(sh_log[14]), 1);
      chk("stall_done",   first_done(), 19);
      for (int k = 0; k < 4; k++) chk($sformatf("stall_cnt%0d", k), cnt_wr(k), 4);
      chk("stall_c3_last", last_wr(3), 18);

      // Full flag on column 3 before its window opens
      run(20, 0, -1, -1, 3, 9, 11, -1);
      chk("idle_full_stall", cnt_stall(), 0);
      chk("idle_full_wr10",  int'(wr_log[10]), 4'b0011);
      chk("idle_full_c3",    first_wr(3, 0), 12);
      chk("idle_full_done",  first_done(), 16);

      // Abort at cycle 11, restart at cycle 14
      run(34, 0, 14, 11, -1, 0, 0, -1);
      chk("abort_wr11",   int'(wr_log[11]), 4'b0111);
      chk("abort_busy12", int'(bz_log[12]), 0);
      chk("abort_wr12",   int'(wr_log[12]), 0);
      chk("abort_busy13", int'(bz_log[13]), 0);
      chk("abort_busy15", int'(bz_log[15]), 1);
      chk("abort_c0_re",  first_wr(0, 12), 23);
      chk("abort_c3_last", last_wr(3), 29);
      chk("abort_done",   first_done(), 30);
      chk("abort_done_n", cnt_done(), 1);

      // Overrun from a second start at cycle 5
      run(20, 0, 5, -1, -1, 0, 0, -1);
      chk("ovr_5",     int'(ov_log[5]), 0);
      chk("ovr_6",     int'(ov_log[6]), 1);
      chk("ovr_19",    int'(ov_log[19]), 1);
      chk("ovr_done",  first_done(), 16);
      chk("ovr_c0",    first_wr(0, 0), 9);
      run(20, 0, -1, -1, -1, 0, 0, -1);
      chk("ovr_keep0", int'(ov_log[0]), 1);
      chk("ovr_clr1",  int'(ov_log[1]), 0);
      chk("ovr_done2", first_done(), 16);

      // Reset pulse mid-drain at cycle 10
      run(22, 0, -1, -1, -1, 0, 0, 10);
      chk("rstm_wr9",    int'(wr_log[9]), 4'b0001);
      chk("rstm_wr10",   int'(wr_log[10]), 0);
      chk("rstm_sh10",   int'(sh_log[10]), 0);
      chk("rstm_busy10", int'(bz_log[10]), 0);
      chk("rstm_busy11", int'(bz_log[11]), 0);
      chk("rstm_done_n", cnt_done(), 0);
      chk("rstm_writes", cnt_wr(0) + cnt_wr(1) + cnt_wr(2) + cnt_wr(3), 1);
      run(20, 0, -1, -1, -1, 0, 0, -1);
      chk("rstm_re_c0",   first_wr(0, 0), 9);
      chk("rstm_re_done", first_done(), 16);
      chk("rstm_re_wr",   cnt_wr(0) + cnt_wr(1) + cnt_wr(2) + cnt_wr(3), 16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
